// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends one command byte
// framed as start/8 data/odd parity/stop, then checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 1400,
  parameter int unsigned SETUP_CYCLES   = 28,
  parameter int unsigned TIMEOUT_CYCLES = 28000
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DAT_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DAT_OE
);

  localparam int unsigned MAX_AB  = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SETUP,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [10:0]   shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          clk_oe_q, clk_oe_d;
  logic          dat_oe_q, dat_oe_d;
  logic          clk_s1_q, clk_s2_q, clk_prev_q;
  logic          dat_s1_q, dat_s2_q;

  logic          fall;
  logic          timed_out;
  logic [3:0]    idx_nx;

  // Synchronizers idle high so a freshly reset bus never looks like an edge.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= PS2_CLK_IN;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= PS2_DAT_IN;
      dat_s2_q   <= dat_s1_q;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      clk_oe_q <= 1'b0;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      clk_oe_q <= clk_oe_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  assign fall      = clk_prev_q & ~clk_s2_q;
  assign timed_out = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign idx_nx    = idx_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    clk_oe_d = clk_oe_q;
    dat_oe_d = dat_oe_q;

    unique case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          shift_d  = {1'b1, ~^tx_data, tx_data, 1'b0};
          busy_d   = 1'b1;
          clk_oe_d = 1'b1;
          dat_oe_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          dat_oe_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_SETUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = S_SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SEND: begin
        // The edge test comes first so an edge beats a same-cycle timeout.
        if (fall) begin
          cnt_d = '0;
          idx_d = idx_nx;
          if (idx_nx == 4'd10) begin
            dat_oe_d = 1'b0;
            state_d  = S_ACK;
          end else begin
            dat_oe_d = ~shift_q[idx_nx];
          end
        end else if (timed_out) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        if (fall) begin
          cnt_d = '0;
          if (!dat_s2_q) begin
            state_d = S_WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else if (timed_out) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s2_q && dat_s2_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (timed_out) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          err_d    = 1'b1;
          busy_d   = 1'b0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        busy_d   = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_error   = err_q;
  assign PS2_CLK_OE = clk_oe_q;
  assign PS2_DAT_OE = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a behavioural PS/2 device that
// clocks the frame in, samples data on rising edges and optionally ACKs.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       CLK = 1'b0;
  logic       nRESET = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       clk_oe, dat_oe;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       bus_clk, bus_dat;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Edge -> 2 sync stages -> registered state: error lands this many cycles late.
  localparam int SYNC_LAT = 3;

  assign bus_clk = dev_clk & ~clk_oe;
  assign bus_dat = dev_dat & ~dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(1400),
    .SETUP_CYCLES  (28),
    .TIMEOUT_CYCLES(28000)
  ) dut (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error),
    .PS2_CLK_IN(bus_clk),
    .PS2_DAT_IN(bus_dat),
    .PS2_CLK_OE(clk_oe),
    .PS2_DAT_OE(dat_oe)
  );

  always #35 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    int          half;
    logic [10:0] exp_bits;
    int          exp_done;
    int          exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_start(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge CLK);
    tx_start = 1'b0;
  endtask

  task automatic dev_frame(input int half, input int npulse, input bit ack,
                           output logic [10:0] bits, output bit ok, output int last_fall);
    int w;
    bits = '0;
    ok = 1'b1;
    last_fall = 0;
    w = 0;
    while (!(dat_oe && !clk_oe) && w < 5000) begin
      @(negedge CLK);
      w++;
    end
    if (w >= 5000) begin
      ok = 1'b0;
      return;
    end
    bits[0] = bus_dat;
    repeat (half) @(negedge CLK);
    for (int i = 1; i <= npulse && i <= 10; i++) begin
      dev_clk = 1'b0;
      last_fall = cyc;
      repeat (half) @(negedge CLK);
      dev_clk = 1'b1;
      bits[i] = bus_dat;
      repeat (half) @(negedge CLK);
    end
    if (npulse > 10) begin
      if (ack) dev_dat = 1'b0;
      repeat (5) @(negedge CLK);
      dev_clk = 1'b0;
      last_fall = cyc;
      repeat (half) @(negedge CLK);
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      repeat (4) @(negedge CLK);
    end
  endtask

  task automatic monitor(input int maxc, output int oe_cyc, output int ndone, output int nerr,
                         output int nbad, output int err_cyc, output bit tmo);
    int   c;
    int   tail;
    logic prev_busy;
    c = 0;
    tail = -1;
    prev_busy = 1'b1;
    oe_cyc = 0; ndone = 0; nerr = 0; nbad = 0; err_cyc = 0; tmo = 1'b0;
    while (1) begin
      if (clk_oe) oe_cyc++;
      if (tx_done) ndone++;
      if (tx_error) begin
        nerr++;
        if (err_cyc == 0) err_cyc = cyc;
      end
      if ((tx_done || tx_error) && (tx_busy || !prev_busy)) nbad++;
      if (tx_done && tx_error) nbad++;
      prev_busy = tx_busy;
      if (tail < 0 && (tx_done || tx_error)) tail = 6;
      if (tail == 0) break;
      if (tail > 0) tail--;
      c++;
      if (c >= maxc) begin
        tmo = 1'b1;
        break;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    logic [10:0] bits;
    bit          ok, tmo;
    int          lf, oe_cyc, ndone, nerr, nbad, ecyc, extra, w;

    vecs[0] = '{8'hED, 1'b1, 560, 11'b1_1_11101101_0, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 20,  11'b1_1_00000000_0, 1, 0};
    vecs[2] = '{8'h01, 1'b1, 20,  11'b1_0_00000001_0, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 20,  11'b1_1_11111111_0, 1, 0};
    vecs[4] = '{8'hA5, 1'b0, 20,  11'b1_1_10100101_0, 0, 1};

    repeat (5) @(negedge CLK);
    check("reset busy", int'(tx_busy), 0);
    check("reset done", int'(tx_done), 0);
    check("reset error", int'(tx_error), 0);
    check("reset clk_oe", int'(clk_oe), 0);
    check("reset dat_oe", int'(dat_oe), 0);
    nRESET = 1'b1;
    repeat (5) @(negedge CLK);

    foreach (vecs[k]) begin
      send_start(vecs[k].data);
      fork
        dev_frame(vecs[k].half, 11, vecs[k].ack, bits, ok, lf);
        monitor(40000, oe_cyc, ndone, nerr, nbad, ecyc, tmo);
      join
      check($sformatf("v%0d dev sync", k), int'(ok), 1);
      check($sformatf("v%0d mon bound", k), int'(tmo), 0);
      check($sformatf("v%0d clk_oe cycles", k), oe_cyc, 1428);
      check($sformatf("v%0d frame bits", k), int'(bits), int'(vecs[k].exp_bits));
      check($sformatf("v%0d done pulses", k), ndone, vecs[k].exp_done);
      check($sformatf("v%0d error pulses", k), nerr, vecs[k].exp_err);
      check($sformatf("v%0d pulse timing", k), nbad, 0);
      check($sformatf("v%0d lines released", k), int'({clk_oe, dat_oe, tx_busy}), 0);
      repeat (20) @(negedge CLK);
    end

    // Device stalls after its 4th falling edge.
    send_start(8'h3C);
    fork
      dev_frame(20, 4, 1'b1, bits, ok, lf);
      monitor(40000, oe_cyc, ndone, nerr, nbad, ecyc, tmo);
    join
    check("tmo mon bound", int'(tmo), 0);
    check("tmo error pulses", nerr, 1);
    check("tmo done pulses", ndone, 0);
    check("tmo latency", ecyc - lf, 28000 + SYNC_LAT);
    check("tmo lines released", int'({clk_oe, dat_oe, tx_busy}), 0);
    repeat (10) @(negedge CLK);
    send_start(8'hF3);
    fork
      dev_frame(20, 11, 1'b1, bits, ok, lf);
      monitor(40000, oe_cyc, ndone, nerr, nbad, ecyc, tmo);
    join
    check("post-tmo bits", int'(bits), int'(11'b1_1_11110011_0));
    check("post-tmo done", ndone, 1);
    check("post-tmo error", nerr, 0);

    // Second tx_start mid-frame must neither alter the byte nor queue a frame.
    repeat (10) @(negedge CLK);
    send_start(8'h12);
    fork
      dev_frame(20, 11, 1'b1, bits, ok, lf);
      monitor(40000, oe_cyc, ndone, nerr, nbad, ecyc, tmo);
      begin
        w = 0;
        while (clk_oe && w < 5000) begin
          @(negedge CLK);
          w++;
        end
        repeat (60) @(negedge CLK);
        send_start(8'h55);
      end
    join
    check("mid bits", int'(bits), int'(11'b1_1_00010010_0));
    check("mid done", ndone, 1);
    extra = 0;
    repeat (3000) begin
      @(negedge CLK);
      if (tx_busy || clk_oe || tx_done || tx_error) extra++;
    end
    check("mid no extra frame", extra, 0);

    // Asynchronous reset while in SEND with the data line pulled low.
    send_start(8'h70);
    dev_frame(20, 3, 1'b1, bits, ok, lf);
    check("rst pre busy", int'(tx_busy), 1);
    check("rst pre dat_oe", int'(dat_oe), 1);
    nRESET = 1'b0;
    #1;
    check("rst async outs", int'({clk_oe, dat_oe, tx_busy}), 0);
    extra = 0;
    repeat (20) begin
      @(negedge CLK);
      if (tx_done || tx_error || tx_busy) extra++;
    end
    nRESET = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (tx_done || tx_error || tx_busy) extra++;
    end
    check("rst no pulses", extra, 0);
    send_start(8'h5A);
    fork
      dev_frame(20, 11, 1'b1, bits, ok, lf);
      monitor(40000, oe_cyc, ndone, nerr, nbad, ecyc, tmo);
    join
    check("post-rst bits", int'(bits), int'(11'b1_1_01011010_0));
    check("post-rst done", ndone, 1);
    check("post-rst clk_oe cycles", oe_cyc, 1428);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
